// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's ROM port, execute redirect input and IF/ID handshake.
// The master modport is the fetch stage; slave is the ROM/execute/decode side.
interface instruction_fetch_if #(
   parameter int unsigned ADDR_W = 16
);
   logic [ADDR_W-1:0] rom_address;
   logic [31:0]       rom_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_pc;

   modport master (
      output rom_address,
      input  rom_data,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   modport slave (
      input  rom_address,
      output rom_data,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM into the IF/ID
// register, handles execute redirects and halts permanently on a misaligned target.
module instruction_fetch #(
   parameter int unsigned      ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset_n,
   instruction_fetch_if.master bus,
   output logic                halted,
   output logic [ADDR_W-1:0]   fault_pc,
   output logic [31:0]         fetch_count
);

   typedef enum logic {
      RUN,
      HALTED
   } state_t;

   generate
      if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
         $error("instruction_fetch: RESET_PC must be word-aligned");
      end
   endgenerate

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
   logic [31:0]       fetch_count_q, fetch_count_d;
   logic              handshake;
   logic              reg_free;

   assign handshake = out_valid_q && bus.out_ready;
   assign reg_free  = !out_valid_q || bus.out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC;
         out_valid_q   <= 1'b0;
         out_instr_q   <= '0;
         out_pc_q      <= '0;
         fault_pc_q    <= '0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         out_valid_q   <= out_valid_d;
         out_instr_q   <= out_instr_d;
         out_pc_q      <= out_pc_d;
         fault_pc_q    <= fault_pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   // A redirect outranks both fetch and stall; a handshake in the redirect cycle
   // still counts because decode already consumed that instruction.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      out_valid_d   = out_valid_q;
      out_instr_d   = out_instr_q;
      out_pc_d      = out_pc_q;
      fault_pc_d    = fault_pc_q;
      fetch_count_d = fetch_count_q + {31'd0, handshake};

      case (state_q)
         RUN: begin
            if (bus.redirect_valid) begin
               out_valid_d = 1'b0;
               if (bus.redirect_pc[1:0] != 2'b00) begin
                  state_d    = HALTED;
                  fault_pc_d = bus.redirect_pc;
               end else begin
                  pc_d = bus.redirect_pc;
               end
            end else if (reg_free) begin
               out_valid_d = 1'b1;
               out_instr_d = bus.rom_data;
               out_pc_d    = pc_q;
               pc_d        = pc_q + ADDR_W'(4);
            end
         end
         HALTED: begin
            out_valid_d = 1'b0;
         end
         default: begin
            state_d     = HALTED;
            out_valid_d = 1'b0;
         end
      endcase
   end

   assign bus.rom_address = pc_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_instr   = out_instr_q;
   assign bus.out_pc      = out_pc_q;
   assign halted          = (state_q == HALTED);
   assign fault_pc        = fault_pc_q;
   assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of per-cycle vectors plus hand-written
// halt and asynchronous-reset sequences, against a bench-side ROM function.
module tb_instruction_fetch;

   localparam int unsigned ADDR_W = 16;

   typedef struct {
      logic        rv;
      logic [15:0] rpc;
      logic        rdy;
      logic        exp_valid;
      logic [15:0] exp_pc;
      logic [15:0] exp_addr;
      logic [31:0] exp_count;
      logic        exp_halted;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              halted;
   logic [ADDR_W-1:0] fault_pc;
   logic [31:0]       fetch_count;
   int                errors = 0;
   int                checks = 0;
   vec_t              vecs[18];

   instruction_fetch_if #(.ADDR_W(ADDR_W)) ifc ();

   instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (ifc.master),
      .halted     (halted),
      .fault_pc   (fault_pc),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [15:0] a);
      return {a, 16'h0000} ^ 32'hA5A5_A5A5;
   endfunction

   assign ifc.rom_data = rom_word(ifc.rom_address);

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic apply_stimulus(input logic rv, input logic [15:0] rpc, input logic rdy);
      ifc.redirect_valid = rv;
      ifc.redirect_pc    = rpc;
      ifc.out_ready      = rdy;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // fields: rv, rpc, rdy | valid, out_pc, rom_address, fetch_count, halted
      vecs[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0004, 32'd0,  1'b0};
      vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0008, 32'd1,  1'b0};
      vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 16'h000C, 32'd2,  1'b0};
      vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h000C, 32'd2,  1'b0};
      vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h000C, 32'd2,  1'b0};
      vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h000C, 32'd2,  1'b0};
      vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C, 16'h0010, 32'd3,  1'b0};
      vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h0014, 32'd4,  1'b0};
      vecs[8]  = '{1'b1, 16'h0008, 1'b1, 1'b0, 16'h0010, 16'h0008, 32'd5,  1'b0};
      vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 16'h000C, 32'd5,  1'b0};
      vecs[10] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0008, 16'h0040, 32'd5,  1'b0};
      vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0044, 32'd5,  1'b0};
      vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0044, 16'h0048, 32'd6,  1'b0};
      vecs[13] = '{1'b1, 16'hFFFC, 1'b1, 1'b0, 16'h0044, 16'hFFFC, 32'd7,  1'b0};
      vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFC, 16'h0000, 32'd7,  1'b0};
      vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0004, 32'd8,  1'b0};
      vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0008, 32'd9,  1'b0};
      vecs[17] = '{1'b1, 16'h0042, 1'b1, 1'b0, 16'h0004, 16'h0008, 32'd10, 1'b1};

      ifc.redirect_valid = 1'b0;
      ifc.redirect_pc    = 16'h0000;
      ifc.out_ready      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_output("reset out_valid",   {31'd0, ifc.out_valid}, 32'd0);
      check_output("reset out_pc",      {16'd0, ifc.out_pc},    32'd0);
      check_output("reset out_instr",   ifc.out_instr,          32'd0);
      check_output("reset rom_address", {16'd0, ifc.rom_address}, 32'd0);
      check_output("reset halted",      {31'd0, halted},        32'd0);
      check_output("reset fault_pc",    {16'd0, fault_pc},      32'd0);
      check_output("reset fetch_count", fetch_count,            32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         apply_stimulus(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
         check_output($sformatf("vec%0d out_valid", i), {31'd0, ifc.out_valid}, {31'd0, vecs[i].exp_valid});
         check_output($sformatf("vec%0d rom_address", i), {16'd0, ifc.rom_address}, {16'd0, vecs[i].exp_addr});
         check_output($sformatf("vec%0d fetch_count", i), fetch_count, vecs[i].exp_count);
         check_output($sformatf("vec%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
         if (vecs[i].exp_valid) begin
            check_output($sformatf("vec%0d out_pc", i), {16'd0, ifc.out_pc}, {16'd0, vecs[i].exp_pc});
            check_output($sformatf("vec%0d out_instr", i), ifc.out_instr, rom_word(vecs[i].exp_pc));
         end
      end

      // Halted: further redirects and ready must change nothing.
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, 16'h0080, 1'b1);
         check_output($sformatf("halt%0d out_valid", i), {31'd0, ifc.out_valid}, 32'd0);
         check_output($sformatf("halt%0d halted", i), {31'd0, halted}, 32'd1);
         check_output($sformatf("halt%0d fault_pc", i), {16'd0, fault_pc}, 32'h0000_0042);
         check_output($sformatf("halt%0d rom_address", i), {16'd0, ifc.rom_address}, 32'h0000_0008);
         check_output($sformatf("halt%0d fetch_count", i), fetch_count, 32'd10);
      end

      // Asynchronous reset out of HALTED, between clock edges.
      ifc.redirect_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check_output("async1 halted",      {31'd0, halted},        32'd0);
      check_output("async1 fetch_count", fetch_count,            32'd0);
      check_output("async1 rom_address", {16'd0, ifc.rom_address}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      apply_stimulus(1'b0, 16'h0000, 1'b1);
      apply_stimulus(1'b0, 16'h0000, 1'b1);
      apply_stimulus(1'b0, 16'h0000, 1'b1);
      check_output("stream out_pc",      {16'd0, ifc.out_pc}, 32'h0000_0008);
      check_output("stream fetch_count", fetch_count,         32'd2);

      // Reset mid-stream, just after a rising edge.
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check_output("async2 out_valid",   {31'd0, ifc.out_valid}, 32'd0);
      check_output("async2 halted",      {31'd0, halted},        32'd0);
      check_output("async2 fetch_count", fetch_count,            32'd0);
      check_output("async2 out_pc",      {16'd0, ifc.out_pc},    32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      apply_stimulus(1'b0, 16'h0000, 1'b1);
      check_output("post-reset out_valid", {31'd0, ifc.out_valid}, 32'd1);
      check_output("post-reset out_pc",    {16'd0, ifc.out_pc},    32'd0);
      check_output("post-reset out_instr", ifc.out_instr,          rom_word(16'h0000));
      apply_stimulus(1'b0, 16'h0000, 1'b1);
      check_output("post-reset next pc",   {16'd0, ifc.out_pc},    32'h0000_0004);
      check_output("post-reset count",     fetch_count,            32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
